jt053247_draw: RTL

JT053247_DRAW -- requirements
Module: jt053247_draw

---
 rtl/jt053247_pkg.sv | 32 +++
 rtl/jt053247_pxlsel.sv | 31 +++
 rtl/jt053247_draw.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/jt053247_pkg.sv
// ============================================================================
// Module : jt053247_pkg
// Brief  : Shared types and constants for the jt053247 sprite line drawer.
//          Holds the draw-engine state encoding, the 1:1 horizontal zoom
//          value, the accumulator end point and the per-tile pixel cap.
// Macro  : JT053247_ZOOM_EN (used by jt053247_draw, not here)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jt053247_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH_L = 2'd1,
    FETCH_R = 2'd2,
    DRAW    = 2'd3
  } state_t;

  localparam logic [9:0]  HZ_UNITY = 10'h040;
  localparam logic [10:0] ACC_END  = 11'd1024;
  localparam logic [8:0]  MAX_PIX  = 9'd511;

  // Mirrored column inside a 16-pixel tile: 15-src is the bitwise inverse.
  function automatic logic [3:0] eff_index(input logic [3:0] src,
                                           input logic       flip);
    return flip ? ~src : src;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jt053247_pxlsel.sv
// ============================================================================
// Module : jt053247_pxlsel
// Brief  : Combinational pixel picker. Applies horizontal flip to the source
//          column and returns the matching nibble of the latched tile row.
// Ports  : row_data in 64  {R word, L word}; source pixel n at [4n+3:4n]
//          src      in 4   unflipped source column
//          hflip    in 1   mirror the tile horizontally
//          pix      out 4  selected pixel
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jt053247_pxlsel
  import jt053247_pkg::*;
(
  input  logic [63:0] row_data,
  input  logic [3:0]  src,
  input  logic        hflip,
  output logic [3:0]  pix
);

  logic [3:0] w_idx;

  always_comb begin
    w_idx = eff_index(src, hflip);
    pix   = row_data[{w_idx, 2'b00} +: 4];
  end

endmodule

`default_nettype wire

// File: rtl/jt053247_draw.sv
// ============================================================================
// Module : jt053247_draw
// Brief  : Sprite tile row drawer. Fetches the two 32-bit halves of one
//          16-pixel tile row from ROM, then writes the row into a line buffer
//          one pixel per clock, optionally zoomed horizontally.
// Macro  : JT053247_ZOOM_EN - when defined, hzoom scales the row and hz_keep
//          carries the zoom accumulator remainder across tiles. Otherwise
//          every tile is drawn 1:1 (16 pixels) and hz_keep only chains columns.
// Ports  : clk, rst_n (sync, active-low)
//          dr_start in / dr_busy out        draw handshake
//          code, attr, shd, hflip, vflip, hpos, ysub, hzoom, hz_keep in
//          rom_addr out 21, rom_cs out, rom_ok in, rom_data in 32
//          buf_addr out 9, buf_data out 16 {shd,attr,pix}, buf_we out
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jt053247_draw #(
  parameter logic [9:0] HZ_UNITY = jt053247_pkg::HZ_UNITY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dr_start,
  output logic        dr_busy,
  input  logic [15:0] code,
  input  logic [9:0]  attr,
  input  logic [1:0]  shd,
  input  logic        hflip,
  input  logic        vflip,
  input  logic [8:0]  hpos,
  input  logic [3:0]  ysub,
  input  logic [9:0]  hzoom,
  input  logic        hz_keep,
  output logic [20:0] rom_addr,
  output logic        rom_cs,
  input  logic        rom_ok,
  input  logic [31:0] rom_data,
  output logic [8:0]  buf_addr,
  output logic [15:0] buf_data,
  output logic        buf_we
);

  import jt053247_pkg::*;

  state_t      r_state, w_state_next;
  logic [15:0] r_code;
  logic [3:0]  r_row;
  logic [9:0]  r_attr;
  logic [1:0]  r_shd;
  logic        r_hflip;
  logic [31:0] r_lo, r_hi;
  logic [10:0] r_acc;
  logic [8:0]  r_col;
  logic [8:0]  r_cnt;
  logic        r_chain;      // a tile has completed since reset: chaining allowed

  logic [9:0]  w_hz;
  logic [10:0] w_acc_sum;
  logic [8:0]  w_cnt_inc;
  logic        w_draw_end;
  logic        w_keep;
  logic [3:0]  w_pix;

`ifdef JT053247_ZOOM_EN
  logic [9:0]  r_hzoom;
  assign w_hz = (r_hzoom == 10'd0) ? 10'd1 : r_hzoom;
`else
  logic        w_unused_hzoom;
  assign w_unused_hzoom = ^hzoom;
  assign w_hz           = HZ_UNITY;
`endif

  assign w_acc_sum  = r_acc + {1'b0, w_hz};
  assign w_cnt_inc  = r_cnt + 9'd1;
  assign w_draw_end = (w_acc_sum >= ACC_END) || (w_cnt_inc == MAX_PIX);
  assign w_keep     = hz_keep & r_chain;

  jt053247_pxlsel u_pxlsel (
    .row_data ({r_hi, r_lo}),
    .src      (r_acc[9:6]),
    .hflip    (r_hflip),
    .pix      (w_pix)
  );

  // Half select is simply "are we fetching the right word".
  assign rom_addr = {r_code, r_row, (r_state == FETCH_R)};
  assign buf_addr = r_col;
  assign buf_data = {r_shd, r_attr, w_pix};

  always_comb begin
    w_state_next = r_state;
    rom_cs       = 1'b0;
    buf_we       = 1'b0;
    dr_busy      = (r_state != IDLE);
    unique case (r_state)
      IDLE:    if (dr_start) w_state_next = FETCH_L;
      FETCH_L: begin
        rom_cs = 1'b1;
        if (rom_ok) w_state_next = FETCH_R;
      end
      FETCH_R: begin
        rom_cs = 1'b1;
        if (rom_ok) w_state_next = DRAW;
      end
      DRAW: begin
        buf_we = (w_pix != 4'd0);
        if (w_draw_end) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_code  <= '0;
      r_row   <= '0;
      r_attr  <= '0;
      r_shd   <= '0;
      r_hflip <= 1'b0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_acc   <= '0;
      r_col   <= '0;
      r_cnt   <= '0;
      r_chain <= 1'b0;
`ifdef JT053247_ZOOM_EN
      r_hzoom <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        IDLE: if (dr_start) begin
          r_code  <= code;
          r_row   <= ysub ^ {4{vflip}};
          r_attr  <= attr;
          r_shd   <= shd;
          r_hflip <= hflip;
          r_cnt   <= '0;
`ifdef JT053247_ZOOM_EN
          r_hzoom <= hzoom;
`endif
          if (w_keep) begin
            // r_col already points one past the last output column.
`ifdef JT053247_ZOOM_EN
            r_acc <= {1'b0, r_acc[9:0]};
`else
            r_acc <= '0;
`endif
          end else begin
            r_col <= hpos;
            r_acc <= '0;
          end
        end
        FETCH_L: if (rom_ok) r_lo <= rom_data;
        FETCH_R: if (rom_ok) r_hi <= rom_data;
        DRAW: begin
          r_col <= r_col + 9'd1;
          r_acc <= w_acc_sum;
          r_cnt <= w_cnt_inc;
          if (w_draw_end) r_chain <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
